// File: rtl/eth_fifo_pkg.sv
// eth_fifo_pkg: shared state encoding and default widths/latency for the fifo frame reader
package eth_fifo_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int LEN_WIDTH_DEF  = 11;
  localparam int RD_LATENCY_DEF = 2;
  localparam int OBUF_DEPTH_DEF = 4;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} frd_state_e;
endpackage

// File: rtl/frame_obuf.sv
// frame_obuf: small synchronous FIFO holding fetched bytes ahead of the TX stream
// ports: clk, rst_n (async low), push/push_data write side, pop read side,
//        head = oldest entry, count = current occupancy
module frame_obuf #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  output logic [DATA_WIDTH-1:0]        head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  always_comb begin
    do_pop = pop && count != '0;
    do_push = push && (count != CW'(DEPTH) || do_pop);
  end
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? ((wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1)) : wr_ptr;
      rd_ptr <= do_pop ? ((rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1)) : rd_ptr;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: pulls one frame of bytes from a fifo_buffer read port and streams it out
// ports: start/frame_len request, fifo_rd_* read port (data RD_LATENCY after rd_en),
//        tx_* valid/ready byte stream with tx_last, busy during the frame, done pulse at the end
module fifo_frame_reader
  import eth_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int RD_LATENCY = RD_LATENCY_DEF,
  parameter int OBUF_DEPTH = OBUF_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic                  busy,
  output logic                  done
);
  localparam int CW = $clog2(OBUF_DEPTH + 1);
  frd_state_e state, state_nx;
  logic [LEN_WIDTH-1:0] rd_remain, tx_remain;
  logic [CW-1:0] obuf_count, inflight;
  logic [RD_LATENCY-1:0] vld_sr;
  logic [DATA_WIDTH-1:0] head;
  logic push, xfer, credit, accept;
  // credit counts bytes already buffered plus bytes still in the read pipeline,
  // so a returning byte always has a free buffer slot
  always_comb begin
    push = vld_sr[RD_LATENCY-1];
    xfer = tx_valid && tx_ready;
    credit = ({1'b0, obuf_count} + {1'b0, inflight}) < (CW + 1)'(OBUF_DEPTH);
    accept = state == IDLE && start && frame_len != '0;
  end
  frame_obuf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(OBUF_DEPTH)) u_obuf (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .push_data(fifo_rd_data),
    .pop(xfer),
    .head(head),
    .count(obuf_count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? ((frame_len != '0) ? FETCH : DONE) : IDLE;
      FETCH: state_nx = (fifo_rd_en && rd_remain == LEN_WIDTH'(1)) ? DRAIN : FETCH;
      DRAIN: state_nx = (xfer && tx_last) ? DONE : DRAIN;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    fifo_rd_en = state == FETCH && rd_remain != '0 && !fifo_rd_empty && credit;
    tx_valid = obuf_count != '0;
    tx_data = tx_valid ? head : '0;
    tx_last = tx_valid && tx_remain == LEN_WIDTH'(1);
    busy = state == FETCH || state == DRAIN;
    done = state == DONE;
  end
  // vld_sr tracks each read strobe through the fifo_buffer's read latency
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_remain <= '0;
      tx_remain <= '0;
      inflight <= '0;
      vld_sr <= '0;
    end else begin
      rd_remain <= accept ? frame_len : rd_remain - LEN_WIDTH'(fifo_rd_en);
      tx_remain <= accept ? frame_len : tx_remain - LEN_WIDTH'(xfer);
      inflight <= inflight + CW'(fifo_rd_en) - CW'(push);
      vld_sr <= (vld_sr << 1) | RD_LATENCY'(fifo_rd_en);
    end
endmodule
